// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the poco_r unified-memory port arbiter.
package poco_mem_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF, DM and memory-side signals of the port arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if #(
    parameter int AW = poco_mem_pkg::AW_DEF,
    parameter int DW = poco_mem_pkg::DW_DEF
) ();

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational priority picker: DM wins ties unless the starvation guard
// forces IF through. Never asserts both grants.
module mem_arb_pick (
    input  logic if_req,
    input  logic dm_req,
    input  logic force_if,
    output logic grant_if,
    output logic grant_dm
);

    // Pick one winner from the (already issue-gated) requests
    always_comb begin
        grant_if = if_req && (!dm_req || force_if);
        grant_dm = dm_req && !(if_req && force_if);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and data memory
// (DM). One access outstanding at a time; the response returns MEM_LAT cycles
// after the grant and a new grant may issue in that same response cycle.
module mem_port_arbiter
    import poco_mem_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LAT - 1);
    localparam logic [SW-1:0] SMAX     = SW'(STARVE_MAX);

    state_t        r_state;
    owner_t        r_owner;
    logic          r_we;
    logic [LW-1:0] r_lat_cnt;
    logic [SW-1:0] r_starve_cnt;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_dm_rdata;

    logic          w_resp;
    logic          w_can_issue;
    logic          w_force_if;
    logic          w_gnt_if;
    logic          w_gnt_dm;
    logic          w_if_resp;
    logic          w_dm_resp;
    logic [DW-1:0] w_resp_data;

    // Issue window and response decode; rst suppresses both so that an
    // access granted in the reset cycle cannot be orphaned
    always_comb begin
        w_resp      = !rst && (r_state == BUSY) && (r_lat_cnt == '0);
        w_can_issue = !rst && ((r_state == IDLE) || (r_lat_cnt == '0));
        w_force_if  = (r_starve_cnt == SMAX);
        w_if_resp   = w_resp && (r_owner == OWN_IF);
        w_dm_resp   = w_resp && (r_owner == OWN_DM);
        w_resp_data = r_we ? '0 : bus.mem_rdata;
    end

    mem_arb_pick u_pick (
        .if_req   (bus.if_req & w_can_issue),
        .dm_req   (bus.dm_req & w_can_issue),
        .force_if (w_force_if),
        .grant_if (w_gnt_if),
        .grant_dm (w_gnt_dm)
    );

    // Drive memory strobes and requester responses from the current winner
    always_comb begin
        bus.if_gnt    = w_gnt_if;
        bus.dm_gnt    = w_gnt_dm;
        bus.mem_en    = w_gnt_if | w_gnt_dm;
        bus.mem_we    = w_gnt_dm & bus.dm_we;
        bus.mem_addr  = w_gnt_dm ? bus.dm_addr : (w_gnt_if ? bus.if_addr : '0);
        bus.mem_wdata = (w_gnt_dm & bus.dm_we) ? bus.dm_wdata : '0;
        bus.if_rvalid = w_if_resp;
        bus.dm_rvalid = w_dm_resp;
        bus.if_rdata  = w_if_resp ? bus.mem_rdata : r_if_rdata;
        bus.dm_rdata  = w_dm_resp ? w_resp_data : r_dm_rdata;
    end

    // Access FSM: latch owner/direction on grant and count down the latency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= OWN_IF;
            r_we      <= 1'b0;
            r_lat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_if || w_gnt_dm) begin
                        r_state   <= BUSY;
                        r_owner   <= w_gnt_dm ? OWN_DM : OWN_IF;
                        r_we      <= w_gnt_dm & bus.dm_we;
                        r_lat_cnt <= LAT_INIT;
                    end
                end
                BUSY: begin
                    if (r_lat_cnt != '0) begin
                        r_lat_cnt <= r_lat_cnt - LW'(1);
                    end else if (w_gnt_if || w_gnt_dm) begin
                        r_owner   <= w_gnt_dm ? OWN_DM : OWN_IF;
                        r_we      <= w_gnt_dm & bus.dm_we;
                        r_lat_cnt <= LAT_INIT;
                    end else begin
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Hold the last returned word for each requester between rvalid pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (w_if_resp) r_if_rdata <= bus.mem_rdata;
            if (w_dm_resp) r_dm_rdata <= w_resp_data;
        end
    end

    // Count consecutive cycles IF waits without a grant, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!bus.if_req || w_gnt_if) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != SMAX) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table on a MEM_LAT=1 instance
// plus hand-written sequences on MEM_LAT=2 and MEM_LAT=3 instances.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst1, rst2, rst3;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus1 ();
    mem_port_arbiter_if bus2 ();
    mem_port_arbiter_if bus3 ();

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1), .STARVE_MAX(4)) u_l1 (
        .clk (clk), .rst (rst1), .bus (bus1)
    );
    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(2), .STARVE_MAX(4)) u_l2 (
        .clk (clk), .rst (rst2), .bus (bus2)
    );
    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(3), .STARVE_MAX(4)) u_l3 (
        .clk (clk), .rst (rst3), .bus (bus3)
    );

    typedef struct {
        int unsigned if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata;
        int unsigned e_if_gnt, e_dm_gnt, e_mem_en, e_mem_we, e_mem_addr, e_mem_wdata;
        int unsigned e_if_rvalid, e_if_rdata, e_dm_rvalid, e_dm_rdata;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        bus1.if_req = 0; bus1.if_addr = '0; bus1.dm_req = 0; bus1.dm_we = 0;
        bus1.dm_addr = '0; bus1.dm_wdata = '0; bus1.mem_rdata = '0;
        bus2.if_req = 0; bus2.if_addr = '0; bus2.dm_req = 0; bus2.dm_we = 0;
        bus2.dm_addr = '0; bus2.dm_wdata = '0; bus2.mem_rdata = '0;
        bus3.if_req = 0; bus3.if_addr = '0; bus3.dm_req = 0; bus3.dm_we = 0;
        bus3.dm_addr = '0; bus3.dm_wdata = '0; bus3.mem_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned lat;
        int unsigned cnt_rv;
        int unsigned n_ifg, n_ifr, c_ifg, c_ifr;
        logic drop_dm, drop_if;

        // Field order: if_req if_addr dm_req dm_we dm_addr dm_wdata mem_rdata |
        //   if_gnt dm_gnt mem_en mem_we mem_addr mem_wdata | if_rv if_rd dm_rv dm_rd
        vecs[0]  = '{0,'h0000,0,0,'h0000,'h0000,'h0000, 0,0,0,0,'h0000,'h0000, 0,'h0000,0,'h0000};
        vecs[1]  = '{1,'h0004,0,0,'h0000,'h0000,'h0000, 1,0,1,0,'h0004,'h0000, 0,'h0000,0,'h0000};
        vecs[2]  = '{0,'h0000,0,0,'h0000,'h0000,'h1234, 0,0,0,0,'h0000,'h0000, 1,'h1234,0,'h0000};
        vecs[3]  = '{0,'h0000,0,0,'h0000,'h0000,'h5555, 0,0,0,0,'h0000,'h0000, 0,'h1234,0,'h0000};
        vecs[4]  = '{1,'h0008,1,1,'h0010,'hBEEF,'h7777, 0,1,1,1,'h0010,'hBEEF, 0,'h1234,0,'h0000};
        vecs[5]  = '{1,'h0008,0,0,'h0000,'h0000,'h7777, 1,0,1,0,'h0008,'h0000, 0,'h1234,1,'h0000};
        vecs[6]  = '{0,'h0000,0,0,'h0000,'h0000,'hCAFE, 0,0,0,0,'h0000,'h0000, 1,'hCAFE,0,'h0000};
        vecs[7]  = '{0,'h0000,0,0,'h0000,'h0000,'h0000, 0,0,0,0,'h0000,'h0000, 0,'hCAFE,0,'h0000};
        vecs[8]  = '{1,'h0030,1,0,'h0020,'h0000,'h0011, 0,1,1,0,'h0020,'h0000, 0,'hCAFE,0,'h0000};
        vecs[9]  = '{1,'h0030,1,0,'h0020,'h0000,'h0011, 0,1,1,0,'h0020,'h0000, 0,'hCAFE,1,'h0011};
        vecs[10] = '{1,'h0030,1,0,'h0020,'h0000,'h0011, 0,1,1,0,'h0020,'h0000, 0,'hCAFE,1,'h0011};
        vecs[11] = '{1,'h0030,1,0,'h0020,'h0000,'h0011, 0,1,1,0,'h0020,'h0000, 0,'hCAFE,1,'h0011};
        vecs[12] = '{1,'h0030,1,0,'h0020,'h0000,'h0011, 1,0,1,0,'h0030,'h0000, 0,'hCAFE,1,'h0011};
        vecs[13] = '{1,'h0030,1,0,'h0020,'h0000,'h0011, 0,1,1,0,'h0020,'h0000, 1,'h0011,0,'h0011};
        vecs[14] = '{0,'h0000,0,0,'h0000,'h0000,'h0022, 0,0,0,0,'h0000,'h0000, 0,'h0011,1,'h0022};
        vecs[15] = '{0,'h0000,0,0,'h0000,'h0000,'h0000, 0,0,0,0,'h0000,'h0000, 0,'h0011,0,'h0022};

        idle_all();
        rst1 = 1; rst2 = 1; rst3 = 1;
        repeat (3) @(negedge clk);
        rst1 = 0; rst2 = 0; rst3 = 0;

        // ---- Vector table on the MEM_LAT=1 instance ----
        for (int i = 0; i < 16; i++) begin
            bus1.if_req    = vecs[i].if_req[0];
            bus1.if_addr   = vecs[i].if_addr[15:0];
            bus1.dm_req    = vecs[i].dm_req[0];
            bus1.dm_we     = vecs[i].dm_we[0];
            bus1.dm_addr   = vecs[i].dm_addr[15:0];
            bus1.dm_wdata  = vecs[i].dm_wdata[15:0];
            bus1.mem_rdata = vecs[i].mem_rdata[15:0];
            #2;
            chk($sformatf("v%0d if_gnt", i),    32'(bus1.if_gnt),    vecs[i].e_if_gnt);
            chk($sformatf("v%0d dm_gnt", i),    32'(bus1.dm_gnt),    vecs[i].e_dm_gnt);
            chk($sformatf("v%0d mem_en", i),    32'(bus1.mem_en),    vecs[i].e_mem_en);
            chk($sformatf("v%0d mem_we", i),    32'(bus1.mem_we),    vecs[i].e_mem_we);
            chk($sformatf("v%0d mem_addr", i),  32'(bus1.mem_addr),  vecs[i].e_mem_addr);
            chk($sformatf("v%0d mem_wdata", i), 32'(bus1.mem_wdata), vecs[i].e_mem_wdata);
            chk($sformatf("v%0d if_rvalid", i), 32'(bus1.if_rvalid), vecs[i].e_if_rvalid);
            chk($sformatf("v%0d if_rdata", i),  32'(bus1.if_rdata),  vecs[i].e_if_rdata);
            chk($sformatf("v%0d dm_rvalid", i), 32'(bus1.dm_rvalid), vecs[i].e_dm_rvalid);
            chk($sformatf("v%0d dm_rdata", i),  32'(bus1.dm_rdata),  vecs[i].e_dm_rdata);
            @(negedge clk);
        end
        bus1.if_req = 0; bus1.dm_req = 0;

        // ---- MEM_LAT=3: DM load, no grant in the two wait cycles ----
        bus3.dm_req = 1; bus3.dm_we = 0; bus3.dm_addr = 16'h0020;
        #2;
        chk("l3 dm_gnt", 32'(bus3.dm_gnt), 1);
        chk("l3 mem_addr", 32'(bus3.mem_addr), 'h0020);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus3.dm_req = 0; bus3.if_req = 1; bus3.if_addr = 16'h0040;
            bus3.mem_rdata = 16'h00AA;
            #2;
            chk($sformatf("l3 wait%0d mem_en", k), 32'(bus3.mem_en), 0);
            chk($sformatf("l3 wait%0d rvalid", k), 32'(bus3.dm_rvalid | bus3.if_rvalid), 0);
        end
        @(negedge clk);
        #2;
        chk("l3 dm_rvalid", 32'(bus3.dm_rvalid), 1);
        chk("l3 dm_rdata", 32'(bus3.dm_rdata), 'h00AA);
        chk("l3 b2b if_gnt", 32'(bus3.if_gnt), 1);
        chk("l3 b2b mem_addr", 32'(bus3.mem_addr), 'h0040);
        lat = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus3.if_req = 0; bus3.mem_rdata = 16'h00BB;
            #2;
            if (bus3.if_rvalid && lat == 0) begin
                lat = c;
                chk("l3 if_rdata", 32'(bus3.if_rdata), 'h00BB);
            end
        end
        chk("l3 if latency", lat, 3);

        // ---- MEM_LAT=2: reset abandons the outstanding access ----
        @(negedge clk);
        bus2.if_req = 1; bus2.if_addr = 16'h0060;
        #2;
        chk("l2 pre-rst if_gnt", 32'(bus2.if_gnt), 1);
        @(negedge clk);
        bus2.if_req = 0; rst2 = 1;
        @(negedge clk);
        rst2 = 0; bus2.mem_rdata = 16'h0999;
        #2;
        chk("l2 post-rst if_gnt", 32'(bus2.if_gnt), 0);
        chk("l2 post-rst dm_gnt", 32'(bus2.dm_gnt), 0);
        chk("l2 post-rst mem_en", 32'(bus2.mem_en), 0);
        chk("l2 post-rst mem_we", 32'(bus2.mem_we), 0);
        chk("l2 post-rst mem_addr", 32'(bus2.mem_addr), 0);
        chk("l2 post-rst mem_wdata", 32'(bus2.mem_wdata), 0);
        chk("l2 post-rst if_rdata", 32'(bus2.if_rdata), 0);
        chk("l2 post-rst dm_rdata", 32'(bus2.dm_rdata), 0);
        cnt_rv = 32'(bus2.if_rvalid) + 32'(bus2.dm_rvalid);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #2;
            cnt_rv += 32'(bus2.if_rvalid) + 32'(bus2.dm_rvalid);
        end
        chk("l2 orphan rvalid count", cnt_rv, 0);

        @(negedge clk);
        bus2.if_req = 1; bus2.if_addr = 16'h0070; bus2.mem_rdata = 16'h0777;
        #2;
        chk("l2 fresh if_gnt", 32'(bus2.if_gnt), 1);
        lat = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus2.if_req = 0;
            #2;
            if (bus2.if_rvalid && lat == 0) begin
                lat = c;
                chk("l2 fresh if_rdata", 32'(bus2.if_rdata), 'h0777);
            end
        end
        chk("l2 fresh latency", lat, 2);

        // ---- MEM_LAT=2: IF waits 3 cycles behind a DM access ----
        @(negedge clk);
        bus2.dm_req = 1; bus2.dm_we = 0; bus2.dm_addr = 16'h0080;
        bus2.if_req = 1; bus2.if_addr = 16'h0090; bus2.mem_rdata = 16'h0123;
        n_ifg = 0; n_ifr = 0; c_ifg = 99; c_ifr = 99;
        drop_dm = 0; drop_if = 0;
        for (int c = 0; c < 8; c++) begin
            if (c != 0) @(negedge clk);
            if (drop_dm) bus2.dm_req = 0;
            if (drop_if) bus2.if_req = 0;
            #2;
            if (bus2.dm_gnt) drop_dm = 1;
            if (bus2.if_gnt) begin
                drop_if = 1;
                n_ifg++;
                c_ifg = c;
                chk("l2 hold mem_addr", 32'(bus2.mem_addr), 'h0090);
            end
            if (bus2.if_rvalid) begin
                n_ifr++;
                c_ifr = c;
            end
        end
        chk("l2 hold if_gnt count", n_ifg, 1);
        chk("l2 hold if_rvalid count", n_ifr, 1);
        chk("l2 hold if_gnt cycle", c_ifg, 2);
        chk("l2 hold if_rvalid cycle", c_ifr, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the instruction-fetch stage (IF) and the data-memory stage (DM) of the poco_r pipeline.
- Accepts request/grant handshakes from both stages and issues one memory access at a time.
- Tracks the memory's fixed read latency and routes each response back to the stage that issued it.
- Favours DM to keep the pipeline draining, with a starvation guard so that IF always progresses.

Parameters:
- AW, 16: address width (word address).
- DW, 16: data width.
- MEM_LAT, 1: cycles from mem_en to valid mem_rdata. Legal range is 1 or greater.
- STARVE_MAX, 4: number of consecutive cycles IF can lose arbitration before it is forced to win.

Ports:
- clk, in, 1: single clock; everything is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- if_req, in, 1: IF requests a read.
- if_addr, in, AW: IF address.
- if_gnt, out, 1: one-cycle pulse; the IF request is issued this cycle.
- if_rvalid, out, 1: one-cycle pulse; if_rdata is valid.
- if_rdata, out, DW: fetched word.
- dm_req, in, 1: DM requests an access.
- dm_we, in, 1: 1 = store, 0 = load.
- dm_addr, in, AW: DM address.
- dm_wdata, in, DW: store data.
- dm_gnt, out, 1: one-cycle pulse; the DM request is issued this cycle.
- dm_rvalid, out, 1: one-cycle pulse; load data is valid, or the store has completed.
- dm_rdata, out, DW: load data. It is 0 for a store completion.
- mem_en, out, 1: memory access strobe.
- mem_we, out, 1: memory write enable.
- mem_addr, out, AW: memory address.
- mem_wdata, out, DW: memory write data.
- mem_rdata, in, DW: memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset values: all outputs are 0, the FSM is in IDLE, the latency counter is 0, and the starvation counter is 0. A reset during an outstanding access abandons it: no rvalid is ever produced for it, and mem_en is 0 in the cycle after reset.
- Requester rules: a requester holds req, addr, we and wdata stable from assertion until it sees its gnt. It may drop req only in the gnt cycle or afterwards. Dropping req earlier is illegal and its effect is undefined.
- Issue: in the grant cycle, gnt, mem_en, mem_we, mem_addr and mem_wdata are all driven combinationally from the winning requester. mem_en is high only in grant cycles.
- Arbitration applies only when the FSM can issue, i.e. it is in IDLE or in the response cycle of BUSY.
  - If only one requester is active, it wins.
  - If both are active, DM wins unless starve_cnt equals STARVE_MAX, in which case IF wins.
  - At most one gnt is asserted per cycle.
- Starvation counter: it increments in every cycle where if_req=1 and if_gnt=0, saturating at STARVE_MAX. It clears on if_gnt, or when if_req=0.
- FSM:
  - IDLE → BUSY on any grant. The owner (IF or DM) and the write flag are latched, and lat_cnt is set to MEM_LAT-1.
  - In BUSY, lat_cnt decrements each cycle. The cycle in which lat_cnt=0 is the response cycle.
  - In the response cycle, the owner's rvalid pulses and its rdata is set to mem_rdata (or 0 for a store).
  - In the same response cycle a new grant may be issued, giving back-to-back operation: the FSM stays in BUSY with the new owner. With no grant it returns to IDLE.
- Latency and throughput:
  - Grant-to-rvalid latency is exactly MEM_LAT cycles.
  - With continuous requests, one access is issued every MEM_LAT cycles.
  - Only one access is ever outstanding.
- Data outputs: if_rdata and dm_rdata hold their last value between rvalid pulses.
- Simultaneous events: a request that arrives in the response cycle competes in that same cycle; there is no extra bubble.

Decomposition:
- Shared package poco_mem_pkg:
  - AW and DW defaults.
  - owner_t enum: OWN_IF, OWN_DM.
  - state_t enum: IDLE, BUSY.
- Sub-module mem_arb_pick: a combinational priority picker with starvation override. Its inputs are if_req, dm_req and force_if; its outputs are grant_if and grant_dm. Everything else stays in the top module.

Test Plan:
- Reset, then single IF read of 0x0004 with mem_rdata=0x1234 (MEM_LAT=1): if_gnt at cycle T, mem_en=1 and mem_addr=0x0004 at T, if_rvalid=1 and if_rdata=0x1234 at T+1. dm_* outputs stay 0 throughout.
- if_req and dm_req asserted together; DM is a store of 0xBEEF to address 0x0010: DM is granted first with mem_we=1 and mem_wdata=0xBEEF. At T+1, dm_rvalid=1 with dm_rdata=0, and if_gnt=1 in the same cycle (back-to-back).
- DM requests continuously and IF requests continuously, with STARVE_MAX=4: IF loses for exactly 4 cycles and wins on the 5th arbitration. The counter is back at 0 afterwards.
- MEM_LAT=3, DM load of 0x0020 with mem_rdata=0x00AA: dm_rvalid fires exactly 3 cycles after dm_gnt. No gnt is asserted during the 2 intermediate cycles, even if IF requests.
- rst pulsed in the cycle after a grant (MEM_LAT=2): no rvalid ever appears for that access. All outputs are 0 in the cycle after rst, and a fresh request after reset completes normally.
- IF req held for 3 cycles while DM holds the memory with MEM_LAT=2: if_addr stays stable, and exactly one if_gnt and exactly one if_rvalid are produced.
